// File: rtl/mouse_target_judge.sv
// Reaction-time judge: after a start pulse, waits for a fresh left click and
// reports whether the cursor was inside the target square, the elapsed
// milliseconds, or a timeout.
//
// Handshake: start is a single-cycle request that is only accepted while idle
// (busy=0); it is dropped silently otherwise. Each accepted start yields
// exactly one result_valid pulse, unless reset aborts the trial. The result
// fields are valid in that cycle and stay stable until the next result.
module mouse_target_judge #(
    parameter int CYCLES_PER_MS = 50000,
    parameter int TARGET_SIZE   = 16,
    parameter int TIMEOUT_MS    = 9999
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [9:0]  x_position,
    input  logic [8:0]  y_position,
    input  logic        leftClick_pressed,
    input  logic        start,
    input  logic [9:0]  target_x,
    input  logic [8:0]  target_y,
    output logic        busy,
    output logic        result_valid,
    output logic        hit,
    output logic        timed_out,
    output logic [13:0] reaction_ms,
    output logic [7:0]  hit_count
);

    localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(CYCLES_PER_MS - 1);
    localparam logic [13:0]   TIMEOUT_VAL = 14'(TIMEOUT_MS);
    localparam logic [13:0]   MS_MAX      = 14'h3fff;
    localparam logic [10:0]   SIZE_X      = 11'(TARGET_SIZE);
    localparam logic [9:0]    SIZE_Y      = 10'(TARGET_SIZE);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ARMED      = 2'd1,
        WAIT_CLICK = 2'd2,
        RESULT     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          btn_q, btn_d;
    logic          btn_prev_q, btn_prev_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [13:0]   ms_q, ms_d;
    logic [9:0]    tx_q, tx_d;
    logic [8:0]    ty_q, ty_d;
    logic          hit_q, hit_d;
    logic          timed_out_q, timed_out_d;
    logic [13:0]   reaction_q, reaction_d;
    logic [7:0]    hit_count_q, hit_count_d;

    logic click_edge;
    logic in_target;
    logic timeout_now;

    // Hit test on live cursor, one bit wider so a target near the screen
    // coordinate limits does not wrap around to zero.
    always_comb begin
        in_target = ({1'b0, x_position} >= {1'b0, tx_q})
                 && ({1'b0, x_position} <  ({1'b0, tx_q} + SIZE_X))
                 && ({1'b0, y_position} >= {1'b0, ty_q})
                 && ({1'b0, y_position} <  ({1'b0, ty_q} + SIZE_Y));
    end

    // Next-state, timing and result logic.
    always_comb begin
        state_d     = state_q;
        btn_d       = leftClick_pressed;
        btn_prev_d  = btn_q;
        presc_d     = presc_q;
        ms_d        = ms_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        hit_d       = hit_q;
        timed_out_d = timed_out_q;
        reaction_d  = reaction_q;
        hit_count_d = hit_count_q;
        click_edge  = btn_q && !btn_prev_q;
        timeout_now = (ms_q == TIMEOUT_VAL);

        // Millisecond timebase runs for the whole active trial.
        if (state_q == ARMED || state_q == WAIT_CLICK) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (ms_q != MS_MAX) begin
                    ms_d = ms_q + 14'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = target_x;
                    ty_d    = target_y;
                    presc_d = '0;
                    ms_d    = '0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // A button held from before start must be released first.
                if (timeout_now) begin
                    hit_d       = 1'b0;
                    timed_out_d = 1'b1;
                    reaction_d  = TIMEOUT_VAL;
                    state_d     = RESULT;
                end else if (!btn_q) begin
                    state_d = WAIT_CLICK;
                end
            end
            WAIT_CLICK: begin
                // A click on the timeout cycle still counts as a click.
                if (click_edge) begin
                    hit_d       = in_target;
                    timed_out_d = 1'b0;
                    reaction_d  = ms_q;
                    state_d     = RESULT;
                end else if (timeout_now) begin
                    hit_d       = 1'b0;
                    timed_out_d = 1'b1;
                    reaction_d  = TIMEOUT_VAL;
                    state_d     = RESULT;
                end
            end
            RESULT: begin
                if (hit_q) begin
                    hit_count_d = hit_count_q + 8'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            btn_q       <= 1'b0;
            btn_prev_q  <= 1'b0;
            presc_q     <= '0;
            ms_q        <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            hit_q       <= 1'b0;
            timed_out_q <= 1'b0;
            reaction_q  <= '0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_d;
            btn_prev_q  <= btn_prev_d;
            presc_q     <= presc_d;
            ms_q        <= ms_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            hit_q       <= hit_d;
            timed_out_q <= timed_out_d;
            reaction_q  <= reaction_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign busy         = (state_q == ARMED) || (state_q == WAIT_CLICK);
    assign result_valid = (state_q == RESULT);
    assign hit          = hit_q;
    assign timed_out    = timed_out_q;
    assign reaction_ms  = reaction_q;
    assign hit_count    = hit_count_q;

endmodule

// File: tb/tb_mouse_target_judge.sv
// Bench for mouse_target_judge with a 10-cycle millisecond, 16-pixel target
// and a 20 ms timeout. Each trial is described by its button waveform and the
// expected outcome is worked out from elapsed cycles with plain arithmetic.
module tb_mouse_target_judge;

    localparam int CPM = 10;
    localparam int TS  = 16;
    localparam int TO  = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x_position;
    logic [8:0]  y_position;
    logic        leftClick_pressed;
    logic        start;
    logic [9:0]  target_x;
    logic [8:0]  target_y;
    logic        busy;
    logic        result_valid;
    logic        hit;
    logic        timed_out;
    logic [13:0] reaction_ms;
    logic [7:0]  hit_count;

    int total  = 0;
    int passed = 0;
    logic [7:0]  exp_hc = 8'd0;
    logic [15:0] exp_q[$];

    mouse_target_judge #(
        .CYCLES_PER_MS(CPM),
        .TARGET_SIZE  (TS),
        .TIMEOUT_MS   (TO)
    ) dut (
        .CLOCK_50         (clk),
        .reset            (reset),
        .x_position       (x_position),
        .y_position       (y_position),
        .leftClick_pressed(leftClick_pressed),
        .start            (start),
        .target_x         (target_x),
        .target_y         (target_y),
        .busy             (busy),
        .result_valid     (result_valid),
        .hit              (hit),
        .timed_out        (timed_out),
        .reaction_ms      (reaction_ms),
        .hit_count        (hit_count)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            leftClick_pressed = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // One trial. Edge 0 accepts start; the button level sampled at edge j is
    // 1 while held from start (j < rel), then 0, then 1 from edge clk_at on.
    task automatic run_trial(input int tx, input int ty, input int cx, input int cy,
                             input bit held, input int rel, input int clk_at,
                             input bit inject);
        int  r;
        bit  is_click;
        bit  in_t;
        bit  e_hit;
        bit  e_to;
        int  e_ms;
        int  res_cyc;
        int  pulses;
        int  seen;
        logic [15:0] e;

        // Outcome from the trial description.
        r        = held ? rel : 0;
        is_click = (r < TO * CPM) && (clk_at > r) && (clk_at <= TO * CPM);
        in_t     = (cx >= tx) && (cx < tx + TS) && (cy >= ty) && (cy < ty + TS);
        e_hit    = is_click && in_t;
        e_to     = !is_click;
        e_ms     = is_click ? (clk_at / CPM) : TO;
        res_cyc  = is_click ? (clk_at + 1) : (TO * CPM + 1);
        exp_q.push_back({e_hit, e_to, 14'(e_ms)});

        pulses = 0;
        seen   = -1;
        e      = '0;
        for (int j = 0; j <= TO * CPM + 30; j++) begin
            start             = (j == 0) || (inject && j == 7 && res_cyc > 9);
            target_x          = (j == 0) ? 10'(tx) : 10'($urandom_range(0, 1023));
            target_y          = (j == 0) ? 9'(ty) : 9'($urandom_range(0, 511));
            x_position        = 10'(cx);
            y_position        = 9'(cy);
            leftClick_pressed = (held && j < rel) || (j >= clk_at);
            @(posedge clk);
            #1;
            if (j == 0) check("busy_after_start", busy, 1);
            if (result_valid) begin
                pulses++;
                seen = j;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("hit", hit, e[15]);
                    check("timed_out", timed_out, e[14]);
                    check("reaction_ms", reaction_ms, e[13:0]);
                    if (e[15]) exp_hc = exp_hc + 8'd1;
                end
            end
            if (j == res_cyc + 1) check("hit_count", hit_count, exp_hc);
        end
        check("result_pulses", pulses, 1);
        check("result_cycle", seen, res_cyc);
        check("busy_after_result", busy, 0);
        check("hit_held", hit, e_hit);
        check("reaction_held", reaction_ms, 14'(e_ms));
        idle_cycles(3);
    endtask

    initial begin
        int tx, ty, cx, cy, rel, clk_at;
        bit held;
        int pulses;

        reset             = 1'b1;
        start             = 1'b0;
        leftClick_pressed = 1'b0;
        x_position        = '0;
        y_position        = '0;
        target_x          = '0;
        target_y          = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_hit", hit, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_reaction", reaction_ms, 0);
        check("rst_hit_count", hit_count, 0);
        reset = 1'b0;
        idle_cycles(2);

        // Basic hit, 57 cycles to click -> 5 ms.
        run_trial(100, 50, 108, 60, 0, 0, 57, 1);
        // Right edge is exclusive, bottom-right inside pixel is a hit.
        run_trial(100, 50, 116, 50, 0, 0, 30, 0);
        run_trial(100, 50, 115, 65, 0, 0, 30, 0);
        // Button held through the whole trial -> timeout from ARMED.
        run_trial(100, 50, 108, 60, 1, 1000, 100000, 0);
        // Held, released, then clicked before the timeout.
        run_trial(100, 50, 108, 60, 1, 40, 90, 1);
        // Target near the coordinate limits must not wrap.
        run_trial(1020, 500, 1023, 511, 0, 0, 25, 0);
        run_trial(1020, 500, 3, 0, 0, 0, 25, 0);
        // Click on the timeout cycle wins; one cycle later is a timeout.
        run_trial(100, 50, 108, 60, 0, 0, TO * CPM, 0);
        run_trial(100, 50, 108, 60, 0, 0, TO * CPM + 1, 0);
        // Click with no button activity at all -> timeout from WAIT_CLICK.
        run_trial(200, 100, 205, 105, 0, 0, 100000, 0);

        // Randomized trials.
        for (int t = 0; t < 12; t++) begin
            tx     = $urandom_range(0, 1023);
            ty     = $urandom_range(0, 511);
            cx     = (tx + $urandom_range(0, 19) - 2) & 1023;
            cy     = (ty + $urandom_range(0, 19) - 2) & 511;
            held   = 1'($urandom_range(0, 1));
            rel    = held ? $urandom_range(1, 220) : 0;
            clk_at = rel + $urandom_range(1, 230);
            run_trial(tx, ty, cx, cy, held, rel, clk_at, 1'($urandom_range(0, 1)));
        end

        // Reset 30 cycles into a trial, together with a start request.
        start             = 1'b1;
        target_x          = 10'd300;
        target_y          = 9'd200;
        x_position        = 10'd305;
        y_position        = 9'd205;
        leftClick_pressed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j < 30; j++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_hit", hit, 0);
        check("mid_rst_timed_out", timed_out, 0);
        check("mid_rst_reaction", reaction_ms, 0);
        check("mid_rst_hit_count", hit_count, 0);
        reset  = 1'b0;
        start  = 1'b0;
        exp_hc = 8'd0;
        exp_q.delete();
        pulses = 0;
        for (int j = 0; j < TO * CPM + 20; j++) begin
            @(posedge clk);
            #1;
            if (result_valid) pulses++;
        end
        check("no_result_after_abort", pulses, 0);

        // A fresh trial after the abort behaves normally.
        run_trial(300, 200, 305, 205, 0, 0, 44, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
